matmul_stream_io: RTL

Stream-side front/back end for the matrix-multiply engine: accepts X and Y matrices as a valid/ready word stream, writes them into the X and Y BRAMs, pulses the engine's start, waits for its done, then reads the Z BRAM out as a valid/ready stream. It is the writer of the BRAMs the engine reads and the reader of the BRAM the engine writes, and it is the initiator of the engine's start/done handshake.

---
 rtl/matmul_pkg.sv | 26 ++
 rtl/matmul_stream_io_if.sv | 41 ++++
 rtl/matmul_z_reader.sv | 96 +++++++++
 rtl/matmul_stream_io.sv | 127 ++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared state encoding and default geometry for the matmul stream front/back end.
package matmul_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_VECTOR_SIZE = 64;
    localparam int MAT_WORDS       = DEF_VECTOR_SIZE * DEF_VECTOR_SIZE;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_X = 4'd1,
        LOAD_Y = 4'd2,
        START  = 4'd3,
        ARM    = 4'd4,
        RUN    = 4'd5,
        RD     = 4'd6,
        WAIT   = 4'd7,
        OUT    = 4'd8
    } state_t;

    // Address of the final element of an n-by-n row-major matrix.
    function automatic int last_index(input int n);
        return (n * n) - 32'sd1;
    endfunction

endpackage

// File: rtl/matmul_stream_io_if.sv
// Stream, BRAM and engine-handshake bundle; master is the controller side.
interface matmul_stream_io_if
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  x_wr_en;
    logic                  y_wr_en;
    logic [ADDR_WIDTH-1:0] x_addr;
    logic [ADDR_WIDTH-1:0] y_addr;
    logic [DATA_WIDTH-1:0] x_din;
    logic [DATA_WIDTH-1:0] y_din;
    logic [ADDR_WIDTH-1:0] z_addr;
    logic [DATA_WIDTH-1:0] z_dout;
    logic                  mm_start;
    logic                  mm_done;
    logic                  busy;

    modport master (
        input  in_valid, in_data, out_ready, z_dout, mm_done,
        output in_ready, out_valid, out_data, out_last,
        output x_wr_en, y_wr_en, x_addr, y_addr, x_din, y_din, z_addr,
        output mm_start, busy
    );

    modport slave (
        output in_valid, in_data, out_ready, z_dout, mm_done,
        input  in_ready, out_valid, out_data, out_last,
        input  x_wr_en, y_wr_en, x_addr, y_addr, x_din, y_din, z_addr,
        input  mm_start, busy
    );

endinterface

// File: rtl/matmul_z_reader.sv
// Drains the Z BRAM as a valid/ready stream: RD presents the address, WAIT
// covers the one-cycle BRAM latency, OUT holds a registered word until accepted.
module matmul_z_reader
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int VECTOR_SIZE = DEF_VECTOR_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  finish,
    output logic [ADDR_WIDTH-1:0] z_addr,
    input  logic [DATA_WIDTH-1:0] z_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(last_index(VECTOR_SIZE));
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic [ADDR_WIDTH-1:0] cnt_s;
    logic                  finish_s;
    logic                  out_valid_r;
    logic                  out_last_r;
    logic [DATA_WIDTH-1:0] out_data_r;

    // Next-state and word-counter decode for the drain sequence.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RD;
                    cnt_s   = ADDR_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            RD:   state_s = WAIT;
            WAIT: state_s = OUT;
            OUT: begin
                if (out_ready && out_last_r) begin
                    state_s  = IDLE;
                    finish_s = 1'b1;
                end else if (out_ready) begin
                    state_s = RD;
                    cnt_s   = cnt_r + CNT_ONE;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = ADDR_ZERO;
            end
        endcase
    end

    // State, counter and output register; z_dout is captured as WAIT ends.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= ADDR_ZERO;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= DATA_ZERO;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            out_valid_r <= (state_s == OUT);
            out_last_r  <= (state_s == OUT) && (cnt_r == LAST_IDX);
            if (state_r == WAIT) begin
                out_data_r <= z_dout;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign z_addr    = (state_r == RD) ? cnt_r : ADDR_ZERO;
    assign finish    = finish_s;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_data_r;

endmodule

// File: rtl/matmul_stream_io.sv
// Loads X then Y from the input stream into their BRAMs, starts the engine,
// waits for its done level and hands the Z drain to matmul_z_reader.
module matmul_stream_io
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int VECTOR_SIZE = DEF_VECTOR_SIZE
) (
    input  logic               clock,
    input  logic               reset,
    matmul_stream_io_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(last_index(VECTOR_SIZE));
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic [ADDR_WIDTH-1:0] cnt_s;
    logic                  in_ready_r;
    logic                  mm_start_r;
    logic                  busy_r;
    logic                  in_hs_s;
    logic                  x_wr_s;
    logic                  y_wr_s;
    logic                  rd_start_s;
    logic                  rd_finish_s;

    assign in_hs_s = bus.in_valid && in_ready_r;
    assign x_wr_s  = in_hs_s && (state_r == LOAD_X);
    assign y_wr_s  = in_hs_s && (state_r == LOAD_Y);

    // Next-state decode; ARM gives the engine one cycle to drop its stale done.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        rd_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_s = LOAD_X;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD_X, LOAD_Y: begin
                if (in_hs_s && (cnt_r == LAST_IDX)) begin
                    cnt_s   = ADDR_ZERO;
                    state_s = (state_r == LOAD_X) ? LOAD_Y : START;
                end else if (in_hs_s) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            START: state_s = ARM;
            ARM:   state_s = RUN;
            RUN: begin
                if (bus.mm_done) begin
                    state_s    = RD;
                    rd_start_s = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            RD: begin
                if (rd_finish_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RD;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = ADDR_ZERO;
            end
        endcase
    end

    // State register; flags decoded from the next state so they align with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= ADDR_ZERO;
            in_ready_r <= 1'b0;
            mm_start_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            in_ready_r <= (state_s == LOAD_X) || (state_s == LOAD_Y);
            mm_start_r <= (state_s == START);
            busy_r     <= (state_s != IDLE);
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.mm_start = mm_start_r;
    assign bus.busy     = busy_r;
    assign bus.x_wr_en  = x_wr_s;
    assign bus.y_wr_en  = y_wr_s;
    assign bus.x_addr   = (state_r == LOAD_X) ? cnt_r : ADDR_ZERO;
    assign bus.y_addr   = (state_r == LOAD_Y) ? cnt_r : ADDR_ZERO;
    assign bus.x_din    = x_wr_s ? bus.in_data : DATA_ZERO;
    assign bus.y_din    = y_wr_s ? bus.in_data : DATA_ZERO;

    matmul_z_reader #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .VECTOR_SIZE (VECTOR_SIZE)
    ) u_z_reader (
        .clock     (clock),
        .reset     (reset),
        .start     (rd_start_s),
        .finish    (rd_finish_s),
        .z_addr    (bus.z_addr),
        .z_dout    (bus.z_dout),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last)
    );

endmodule
